// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core network types: the remote request payload and the issue-stage FSM states.
package bsg_vanilla_pkg;

  typedef struct packed {
    logic        write_not_read;
    logic [3:0]  mask;
    logic [4:0]  reg_id;
    logic [31:0] addr;
    logic [31:0] data;
  } remote_req_s;

  typedef enum logic {e_issue, e_fence} remote_req_issue_state_e;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down credit counter that resets to init_val_p; an over/underflow is a protocol error that holds the count.
module bsg_counter_up_down #(
  parameter int max_val_p  = 16,
  parameter int init_val_p = 16,
  parameter int width_p    = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp  = width_p'(max_val_p);
  localparam logic [width_p-1:0] init_lp = width_p'(init_val_p);

  logic [width_p-1:0] r_count;
  logic               w_at_max;
  logic               w_at_zero;

  assign w_at_max  = (r_count == max_lp);
  assign w_at_zero = (r_count == '0);
  assign count_o   = r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= init_lp;
    end else if (up_i && !down_i && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end else if (down_i && !up_i && !w_at_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(up_i && !down_i && w_at_max));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(down_i && !up_i && w_at_zero));

endmodule

// File: rtl/remote_req_issue.sv
// Issue stage onto the transmitter's valid-credit remote-request port, with link/outstanding budgets and fence.
// Optional stall-cause pulse outputs are enabled by defining REMOTE_REQ_ISSUE_STATS_EN.
module remote_req_issue
  import bsg_vanilla_pkg::*;
#(
  parameter  int max_out_credits_p       = 16,
  parameter  int ep_credits_p            = 4,
  localparam int credit_counter_width_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               req_v_i,
  input  remote_req_s                        req_i,
  output logic                               req_ready_o,
  input  logic                               fence_v_i,
  output logic                               fence_done_o,
  output logic                               remote_req_v_o,
  output remote_req_s                        remote_req_o,
  input  logic                               remote_req_credit_i,
  input  logic                               invalid_eva_access_i,
  input  logic                               resp_v_i,
  output logic [credit_counter_width_lp-1:0] out_credits_o
`ifdef REMOTE_REQ_ISSUE_STATS_EN
  ,output logic                              stall_ep_credit_o
  ,output logic                              stall_out_credit_o
  ,output logic                              stall_fence_o
`endif
);

  localparam int ep_width_lp = $clog2(ep_credits_p + 1);
  localparam logic [credit_counter_width_lp-1:0] all_free_lp =
    credit_counter_width_lp'(max_out_credits_p);

  remote_req_issue_state_e r_state, w_state_n;
  logic [ep_width_lp-1:0]  w_ep_cnt;
  logic                    w_accept;
  logic                    w_retire;
  logic                    w_drained;
  logic                    r_remote_req_v;
  remote_req_s             r_remote_req;

  assign req_ready_o = (r_state == e_issue) && (w_ep_cnt != '0)
                       && (out_credits_o != '0) && !fence_v_i;
  assign w_accept    = req_v_i && req_ready_o;
  // A dropped request never gets a response, so it retires its slot directly.
  assign w_retire    = resp_v_i || (invalid_eva_access_i && r_remote_req_v);
  assign w_drained   = (out_credits_o == all_free_lp) && !r_remote_req_v;

  bsg_counter_up_down #(
    .max_val_p (ep_credits_p),
    .init_val_p(ep_credits_p),
    .width_p   (ep_width_lp)
  ) u_ep_credits (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (remote_req_credit_i),
    .down_i (w_accept),
    .count_o(w_ep_cnt)
  );

  // Counts free outstanding slots so out_credits_o comes straight from a flop.
  bsg_counter_up_down #(
    .max_val_p (max_out_credits_p),
    .init_val_p(max_out_credits_p),
    .width_p   (credit_counter_width_lp)
  ) u_out_credits (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (w_retire),
    .down_i (w_accept),
    .count_o(out_credits_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_issue;
    end else begin
      r_state <= w_state_n;
    end
  end

  // NOTE: a default assignment first keeps combinational blocks free of inferred latches.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      e_issue: if (fence_v_i) w_state_n = e_fence;
      e_fence: if (w_drained) w_state_n = e_issue;
      default: w_state_n = e_issue;
    endcase
  end

  always_comb begin
    fence_done_o = 1'b0;
    if (r_state == e_fence) fence_done_o = w_drained;
  end

  // NOTE: the payload is datapath; it is reset only because the port must read zero out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_remote_req_v <= 1'b0;
      r_remote_req   <= '0;
    end else begin
      r_remote_req_v <= w_accept;
      if (w_accept) r_remote_req <= req_i;
    end
  end

  assign remote_req_v_o = r_remote_req_v;
  assign remote_req_o   = r_remote_req;

`ifdef REMOTE_REQ_ISSUE_STATS_EN
  logic w_blocked;
  logic w_fence_cause;
  logic r_stall_ep, r_stall_out, r_stall_fence;

  assign w_blocked     = req_v_i && !req_ready_o;
  assign w_fence_cause = (r_state == e_fence) || fence_v_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_stall_ep    <= 1'b0;
      r_stall_out   <= 1'b0;
      r_stall_fence <= 1'b0;
    end else begin
      r_stall_fence <= w_blocked && w_fence_cause;
      r_stall_out   <= w_blocked && !w_fence_cause && (out_credits_o == '0);
      r_stall_ep    <= w_blocked && !w_fence_cause && (out_credits_o != '0) && (w_ep_cnt == '0);
    end
  end

  assign stall_ep_credit_o  = r_stall_ep;
  assign stall_out_credit_o = r_stall_out;
  assign stall_fence_o      = r_stall_fence;
`endif

endmodule

// File: tb/tb_remote_req_issue.sv
// Scoreboard bench for remote_req_issue: a cycle model predicts ready/credits/fence and queues expected requests.
module tb_remote_req_issue;
  import bsg_vanilla_pkg::*;

  localparam int MAX_OUT = 16;
  localparam int EP      = 4;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          req_v_i = 1'b0;
  remote_req_s   req_i = '0;
  logic          req_ready_o;
  logic          fence_v_i = 1'b0;
  logic          fence_done_o;
  logic          remote_req_v_o;
  remote_req_s   remote_req_o;
  logic          remote_req_credit_i = 1'b0;
  logic          invalid_eva_access_i = 1'b0;
  logic          resp_v_i = 1'b0;
  logic [CW-1:0] out_credits_o;
`ifdef REMOTE_REQ_ISSUE_STATS_EN
  logic          stall_ep_credit_o, stall_out_credit_o, stall_fence_o;
`endif

  always #5 clk_i = ~clk_i;

  remote_req_issue #(.max_out_credits_p(MAX_OUT), .ep_credits_p(EP)) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .req_v_i             (req_v_i),
    .req_i               (req_i),
    .req_ready_o         (req_ready_o),
    .fence_v_i           (fence_v_i),
    .fence_done_o        (fence_done_o),
    .remote_req_v_o      (remote_req_v_o),
    .remote_req_o        (remote_req_o),
    .remote_req_credit_i (remote_req_credit_i),
    .invalid_eva_access_i(invalid_eva_access_i),
    .resp_v_i            (resp_v_i),
    .out_credits_o       (out_credits_o)
`ifdef REMOTE_REQ_ISSUE_STATS_EN
    ,.stall_ep_credit_o  (stall_ep_credit_o)
    ,.stall_out_credit_o (stall_out_credit_o)
    ,.stall_fence_o      (stall_fence_o)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  remote_req_s exp_q[$];
  int          m_ep, m_out;
  bit          m_fence, m_vld;
  bit          m_sf, m_so, m_se;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic remote_req_s mk_req();
    remote_req_s r;
    r.write_not_read = 1'($urandom_range(0, 1));
    r.mask           = 4'($urandom);
    r.reg_id         = 5'($urandom);
    r.addr           = $urandom;
    r.data           = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_ep = EP; m_out = 0; m_fence = 0; m_vld = 0;
    m_sf = 0; m_so = 0; m_se = 0;
    exp_q.delete();
  endtask

  // Compare outputs at the falling edge, then advance the model across the next rising edge.
  task automatic tick();
    bit          rdy, done, acc, retire, blocked, fcause;
    remote_req_s want;
    @(negedge clk_i);
    rdy  = !m_fence && (m_ep != 0) && (m_out != MAX_OUT) && !fence_v_i;
    done = m_fence && (m_out == 0) && !m_vld;
    check("req_ready", 128'(req_ready_o), 128'(rdy));
    check("out_credits", 128'(out_credits_o), 128'(MAX_OUT - m_out));
    check("fence_done", 128'(fence_done_o), 128'(done));
    check("remote_req_v", 128'(remote_req_v_o), 128'(m_vld));
    if (remote_req_v_o) begin
      check("scoreboard_nonempty", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("remote_req", 128'(remote_req_o), 128'(want));
      end
    end
`ifdef REMOTE_REQ_ISSUE_STATS_EN
    check("stall_fence", 128'(stall_fence_o), 128'(m_sf));
    check("stall_out", 128'(stall_out_credit_o), 128'(m_so));
    check("stall_ep", 128'(stall_ep_credit_o), 128'(m_se));
`endif
    blocked = req_v_i && !rdy;
    fcause  = m_fence || fence_v_i;
    m_sf    = blocked && fcause;
    m_so    = blocked && !fcause && (m_out == MAX_OUT);
    m_se    = blocked && !fcause && (m_out != MAX_OUT) && (m_ep == 0);
    acc     = req_v_i && rdy;
    retire  = resp_v_i || (invalid_eva_access_i && m_vld);
    m_ep    = m_ep + int'(remote_req_credit_i) - int'(acc);
    m_out   = m_out + int'(acc) - int'(retire);
    if (!m_fence && fence_v_i) m_fence = 1;
    else if (done)             m_fence = 0;
    m_vld = acc;
    if (acc) exp_q.push_back(req_i);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(bit v, bit cr, bit rs, bit iv, bit fv);
    req_v_i              = v;
    if (v) req_i         = mk_req();
    remote_req_credit_i  = cr;
    resp_v_i             = rs;
    invalid_eva_access_i = iv;
    fence_v_i            = fv;
    tick();
  endtask

  task automatic do_reset();
    req_v_i = 0; remote_req_credit_i = 0; resp_v_i = 0;
    invalid_eva_access_i = 0; fence_v_i = 0;
    reset_i = 1'b1;
    #1;
    check("rst_remote_req_v", 128'(remote_req_v_o), 128'(0));
    check("rst_remote_req", 128'(remote_req_o), 128'(0));
    check("rst_out_credits", 128'(out_credits_o), 128'(MAX_OUT));
    check("rst_fence_done", 128'(fence_done_o), 128'(0));
    model_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Single store: visible for exactly one cycle, one slot and one link credit consumed.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Link-credit exhaustion: only EP of 6 back-to-back requests go out until a credit returns.
    repeat (6) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (4) drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);

    // Outstanding exhaustion with credit return overlapping each accept.
    drive(1, 0, 0, 0, 0);
    repeat (15) drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    repeat (11) drive(0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    repeat (5) drive(0, 0, 1, 0, 0);

    // Fence with three outstanding.
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 1, 0, 1);
    drive(1, 0, 1, 0, 1);
    drive(1, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0);

    // Dropped request retires its slot; fence then completes with no response.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);

    // Reset during a pending fence, then reset with a request in flight.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    do_reset();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
